// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_ctrl #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;
  localparam int BSEL_W = WSEL_W + 5;

  typedef enum logic [1:0] {IDLE, WBACK, REFILL, FILL} state_t;

  state_t                 state_q;
  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [LINE_BITS-1:0]   data_q [LINES];
  logic [LINE_BITS-1:0]   fill_q;
  logic                   mem_req_q;
  logic                   mem_write_q;
  logic [31:0]            mem_addr_q;
  logic [LINE_BITS-1:0]   mem_data_q;

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag_in;
  logic [WSEL_W-1:0]      wsel;
  logic [BSEL_W-1:0]      bit_sel;
  logic                   hit;
  logic                   victim_dirty;
  logic [31:0]            refill_addr;
  logic [31:0]            victim_addr;
  logic [31:0]            sel_word;
  logic                   unused_addr_bits;

  // Address decode; the byte-in-word bits carry no meaning for word accesses.
  assign idx              = cpu_addr_i[OFF_W +: IDX_W];
  assign tag_in           = cpu_addr_i[31 -: TAG_W];
  assign wsel             = cpu_addr_i[2 +: WSEL_W];
  assign bit_sel          = {wsel, 5'd0};
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // Lookup is only meaningful in IDLE; other states are servicing a miss.
  assign hit          = (state_q == IDLE) & cpu_req_i & valid_q[idx] & (tag_q[idx] == tag_in);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];
  assign refill_addr  = {tag_in, idx, {OFF_W{1'b0}}};
  assign victim_addr  = {tag_q[idx], idx, {OFF_W{1'b0}}};
  assign sel_word     = data_q[idx][bit_sel +: 32];

  assign cpu_data_o  = (hit & ~cpu_write_i) ? sel_word : 32'd0;
  assign cpu_stall_o = (state_q == IDLE) ? (cpu_req_i & ~hit) : 1'b1;

  assign mem_req_o   = mem_req_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

  // Miss-handling FSM with registered memory-port outputs and per-line valid/dirty bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      fill_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit && cpu_write_i) begin
            dirty_q[idx] <= 1'b1;
          end
          if (cpu_req_i && !hit) begin
            mem_req_q <= 1'b1;
            if (victim_dirty) begin
              state_q     <= WBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= victim_addr;
              mem_data_q  <= data_q[idx];
            end else begin
              state_q     <= REFILL;
              mem_write_q <= 1'b0;
              mem_addr_q  <= refill_addr;
              mem_data_q  <= '0;
            end
          end
        end
        WBACK: begin
          // Request stays asserted; only direction, address and data switch to the fetch.
          if (mem_ack_i) begin
            state_q     <= REFILL;
            mem_write_q <= 1'b0;
            mem_addr_q  <= refill_addr;
            mem_data_q  <= '0;
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state_q     <= FILL;
            fill_q      <= mem_data_i;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
          end
        end
        FILL: begin
          state_q      <= IDLE;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays need no reset; valid bits gate every use of them.
  always_ff @(posedge clk_i) begin
    if (state_q == FILL) begin
      data_q[idx] <= fill_q;
      tag_q[idx]  <= tag_in;
    end else if (hit && cpu_write_i) begin
      data_q[idx][bit_sel +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_write = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int lat = 1;
  int mcnt = 0;

  logic [31:0]  log_addr [$];
  logic         log_wr   [$];
  logic [255:0] log_data [$];

  dcache_ctrl #(.LINES(16), .LINE_BITS(256)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_write_i(cpu_write), .cpu_addr_i(cpu_addr),
    .cpu_data_i(cpu_wdata), .cpu_data_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [31:0] la);
    logic [255:0] p;
    for (int w = 0; w < 8; w++) begin
      p[w*32 +: 32] = la ^ (32'h0101_0101 * (w + 1)) ^ 32'hA5A5_0000;
    end
    return p;
  endfunction

  function automatic logic [31:0] patw(input logic [31:0] la, input int w);
    logic [255:0] p;
    p = pat(la);
    return p[w*32 +: 32];
  endfunction

  // Memory model: acks in the lat-th cycle of each request, logs every completed transfer.
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      mcnt = mcnt + 1;
      if (mcnt == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = pat(mem_addr);
        log_addr.push_back(mem_addr);
        log_wr.push_back(mem_write);
        log_data.push_back(mem_wdata);
        mcnt = 0;
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      mcnt = 0;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int stalls, output logic [31:0] rdata);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
    stalls = 0;
    #2;
    while (cpu_stall && stalls < 100) begin
      stalls++;
      @(posedge clk); #3;
    end
    rdata = cpu_rdata;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_write = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int base;
    int k;
    logic [31:0] rd;
    logic found;

    // Reset state
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_wdata, 0);
    check("rst_cpu_data", cpu_rdata, 0);
    check("rst_stall_idle", cpu_stall, 0);
    cpu_req = 1'b1; #1;
    check("rst_stall_req", cpu_stall, 1);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean load miss, N=3
    lat = 3;
    do_access(1'b0, 32'h0000_0104, 32'h0, st, rd);
    check("miss1_stalls", st, 5);
    check("miss1_data", rd, patw(32'h100, 1));
    check("miss1_log_n", log_addr.size(), 1);
    if (log_addr.size() >= 1) begin
      check("miss1_addr", log_addr[0], 32'h100);
      check("miss1_wr", log_wr[0], 0);
    end
    check("miss1_valid8", dut.valid_q[8], 1);
    check("miss1_dirty8", dut.dirty_q[8], 0);

    // Hit vectors on line 8
    vecs[0] = '{1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0108, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_010B, 32'h0,         32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0000_0100, 32'h0,         patw(32'h100, 0)};
    vecs[4] = '{1'b1, 32'h0000_011C, 32'h1234_5678, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_011C, 32'h0,         32'h1234_5678};
    vecs[6] = '{1'b0, 32'h0000_0104, 32'h0,         patw(32'h100, 1)};
    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rd);
      check($sformatf("vec%0d_stalls", i), st, 0);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_rdata);
    end
    check("hit_dirty8", dut.dirty_q[8], 1);

    // Dirty miss, N=2: write-back then refill
    lat = 2;
    base = log_addr.size();
    do_access(1'b0, 32'h0000_2108, 32'h0, st, rd);
    check("dmiss_stalls", st, 6);
    check("dmiss_data", rd, patw(32'h2100, 2));
    check("dmiss_log_n", log_addr.size(), base + 2);
    if (log_addr.size() >= base + 2) begin
      check("wb_addr", log_addr[base], 32'h100);
      check("wb_wr", log_wr[base], 1);
      check("wb_word2", log_data[base][95:64], 32'hDEAD_BEEF);
      check("wb_word7", log_data[base][255:224], 32'h1234_5678);
      check("wb_word0", log_data[base][31:0], patw(32'h100, 0));
      check("rf_addr", log_addr[base+1], 32'h2100);
      check("rf_wr", log_wr[base+1], 0);
    end
    check("dmiss_dirty8", dut.dirty_q[8], 0);

    // Store miss on invalid line 2, N=1
    lat = 1;
    do_access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, st, rd);
    check("smiss_stalls", st, 3);
    check("smiss_log_addr", log_addr[log_addr.size()-1], 32'h40);
    check("smiss_dirty2", dut.dirty_q[2], 1);
    do_access(1'b0, 32'h0000_0040, 32'h0, st, rd);
    check("smiss_w0", rd, 32'hCAFE_F00D);
    do_access(1'b0, 32'h0000_0044, 32'h0, st, rd);
    check("smiss_w1", rd, patw(32'h40, 1));
    do_access(1'b0, 32'h0000_005C, 32'h0, st, rd);
    check("smiss_w7", rd, patw(32'h40, 7));

    // Reset asserted during WBACK
    do_access(1'b1, 32'h0000_2108, 32'h55AA_55AA, st, rd);
    check("dirty_again_stalls", st, 0);
    lat = 10;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0104;
    found = 1'b0;
    k = 0;
    #2;
    while (!found && k < 20) begin
      if (mem_req && mem_write) found = 1'b1;
      else begin
        k++;
        @(posedge clk); #3;
      end
    end
    check("wb_started", found, 1);
    rst = 1'b1;
    #1;
    check("rst_async_req", mem_req, 0);
    check("rst_async_write", mem_write, 0);
    check("rst_async_stall", cpu_stall, 1);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;
    lat = 2;
    base = log_addr.size();
    do_access(1'b0, 32'h0000_2108, 32'h0, st, rd);
    check("post_rst_stalls", st, 4);
    check("post_rst_log_n", log_addr.size(), base + 1);
    if (log_addr.size() >= base + 1) begin
      check("post_rst_wr", log_wr[base], 0);
      check("post_rst_addr", log_addr[base], 32'h2100);
    end
    check("post_rst_data", rd, patw(32'h2100, 2));

    // Request dropped during REFILL
    lat = 4;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0260;
    found = 1'b0;
    k = 0;
    #2;
    while (!found && k < 20) begin
      if (mem_req) found = 1'b1;
      else begin
        k++;
        @(posedge clk); #3;
      end
    end
    check("drop_refill_started", found, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    found = 1'b0;
    k = 0;
    #2;
    while (!found && k < 30) begin
      if (!cpu_stall && !mem_req) found = 1'b1;
      else begin
        k++;
        @(posedge clk); #3;
      end
    end
    check("drop_stall_released", found, 1);
    check("drop_valid3", dut.valid_q[3], 1);
    check("drop_dirty3", dut.dirty_q[3], 0);
    check("drop_log_addr", log_addr[log_addr.size()-1], 32'h260);
    do_access(1'b0, 32'h0000_0264, 32'h0, st, rd);
    check("drop_hit_stalls", st, 0);
    check("drop_hit_data", rd, patw(32'h260, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage of the pipelined CPU. It serves the stage's load/store requests from internal tag/data arrays, and refills or evicts 256-bit lines over a request/acknowledge port to data memory. On a miss it raises `cpu_stall_o`, which freezes the pipeline registers, including the hold enable of the MEM/WB register. Load data goes straight to the MEM/WB register's read-data input.

## Interface
- `LINES`, 16: number of cache lines; index width = log2(LINES) = 4.
- `LINE_BITS`, 256: line size (32 bytes, 8 words); offset = `addr[4:0]`, word select = `addr[4:2]`, tag = `addr[31:9]` (23 bits).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cpu_req_i`  in  1  MEM-stage access valid (MemRead | MemWrite).
- `cpu_write_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address; bits [1:0] ignored.
- `cpu_data_i`  in  32  store data.
- `cpu_data_o`  out  32  load data; valid when `cpu_req_i & ~cpu_stall_o`.
- `cpu_stall_o`  out  1  pipeline stall / MEM/WB hold.
- `mem_req_o`  out  1  memory request; held until acknowledged.
- `mem_write_o`  out  1  1 = write-back of dirty line, 0 = line fetch.
- `mem_addr_o`  out  32  line-aligned address (bits [4:0] = 0).
- `mem_data_o`  out  256  evicted line data.
- `mem_data_i`  in  256  fetched line data; sampled with `mem_ack_i`.
- `mem_ack_i`  in  1  one-cycle completion pulse.

## Operation
- Storage per line: valid, dirty, 23-bit tag, 256-bit data. Reset clears only valid and dirty; tag and data contents are don't-care.
- Hit: `hit = cpu_req_i & valid[idx] & (tag[idx] == addr[31:9])`. Evaluated combinationally, only in `IDLE`.
- `cpu_data_o` = selected word of the line on a load hit, else 0.
- `cpu_stall_o = cpu_req_i & ~hit` in `IDLE`; 1 in every other state.
- Store hit: at the clock edge, write `cpu_data_i` into word `addr[4:2]` and set dirty.
- FSM states: `IDLE`, `WBACK`, `REFILL`, `FILL`.
  - `IDLE`, miss and victim valid & dirty -> `WBACK`.
  - `IDLE`, miss otherwise -> `REFILL`.
  - `WBACK`: `mem_req_o=1`, `mem_write_o=1`, `mem_addr_o={victim_tag,idx,5'b0}`, `mem_data_o`=victim line. On `mem_ack_i` -> `REFILL`.
  - `REFILL`: `mem_req_o=1`, `mem_write_o=0`, `mem_addr_o={addr[31:9],idx,5'b0}`. On `mem_ack_i`, latch `mem_data_i` -> `FILL`.
  - `FILL`: write the latched line, set tag, valid=1, dirty=0 -> `IDLE`. The access retries in `IDLE` and now hits; a store then merges and sets dirty.
- `mem_ack_i` is ignored in `IDLE` and `FILL`.
- `cpu_addr_i`, `cpu_write_i` and `cpu_data_i` are stable while stalled. The controller does not re-latch them.
- If `cpu_req_i` drops mid-miss, the transaction still completes through `FILL`. There is no abort.
- Outputs in `IDLE` and `FILL`: `mem_req_o=0`, `mem_write_o=0`, `mem_addr_o=0`, `mem_data_o=0`.

## Timing
- Reset (async, immediate): state `IDLE`, all valid=0, dirty=0. Outputs: `mem_req_o=0`, `mem_write_o=0`, `mem_addr_o=0`, `mem_data_o=0`, `cpu_data_o=0`. `cpu_stall_o` = `cpu_req_i`, since every access misses.
- Reset mid-miss aborts the memory transaction; `mem_req_o` falls with `rst_i`, not at a clock edge.
- Hit latency 0: data and store take effect in the same cycle, with no stall.
- Let memory assert `mem_ack_i` in the N-th cycle of `mem_req_o` (N ≥ 1).
  - Clean miss: `cpu_stall_o` high for N+2 cycles (1 detect, N refill, 1 fill). Hit cycle follows.
  - Dirty miss: stall high for 2N+2 cycles. `mem_req_o` stays high across the `WBACK`→`REFILL` boundary; `mem_write_o` and `mem_addr_o` change on that edge.
- Back-to-back misses to different lines: each starts from `IDLE`. There is no overlap.

## Test plan
- Reset, then load 0x0000_0104 with memory ack latency N=3 -> stall 5 cycles; one `REFILL` at `mem_addr_o=0x0000_0100`; then `cpu_data_o` = word 1 of the returned line; valid[8]=1, dirty=0.
- Store 0xDEAD_BEEF to 0x0000_0108 (hit on that line) -> no stall; dirty[8]=1; a load from 0x108 next cycle returns 0xDEAD_BEEF.
- Load 0x0000_2108 (same index 8, different tag), N=2 -> `WBACK` to 0x0000_0100 with word 2 = 0xDEAD_BEEF, then `REFILL` 0x0000_2100; stall 6 cycles; dirty[8]=0.
- Store miss to 0x0000_0040 on an invalid line -> `REFILL` 0x0000_0040, then the store merges into word 0 in the retry cycle; dirty[2]=1; other words are unchanged from memory.
- Assert `rst_i` during `WBACK` -> `mem_req_o` drops asynchronously; the next load of 0x0000_2108 misses as a clean miss with no write-back.
- Drop `cpu_req_i` during `REFILL` -> ack still consumed, line installed valid; `cpu_stall_o` returns to 0 in `IDLE`.
